bcd_counter_n: RTL and testbench

Parametrised N-digit cascaded BCD counter with up/down count, synchronous parallel load, wrap carry/borrow pulse, sticky overflow flag and a snapshot (hold) register. It is the next-generation replacement for the fixed 6-digit up-only decade counter used in the frequency-meter front end. It is clocked directly by the measured signal F_IN, and the downstream display or readout logic samples Q or HOLD.

---
 rtl/bcd_pkg.sv | 16 +
 rtl/bcd_digit.sv | 46 ++++
 rtl/bcd_counter_n.sv | 87 ++++++++
 tb/tb_bcd_counter_n.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// bcd_pkg: shared BCD types and helpers for the cascaded decade counter.
//   bcd_digit_t : one packed BCD decade
//   BCD_MAX/MIN : decade bounds
//   bcd_sat()   : clamp a nibble into the legal decimal range
package bcd_pkg;

   typedef logic [3:0] bcd_digit_t;

   localparam bcd_digit_t BCD_MAX = 4'd9;
   localparam bcd_digit_t BCD_MIN = 4'd0;

   function automatic bcd_digit_t bcd_sat(input bcd_digit_t n);
      return (n > BCD_MAX) ? BCD_MAX : n;
   endfunction

endpackage

// File: rtl/bcd_digit.sv
// bcd_digit: one BCD decade with load and up/down step.
//   F_IN   : count clock (rising edge)
//   CLR    : asynchronous active-high clear
//   ld     : synchronous load of ld_val (clamped to 9), overrides step
//   ld_val : load nibble
//   step   : advance this decade one position in direction up
//   up     : 1 = increment, 0 = decrement
//   q      : current decade value
//   is_max : q == 9
//   is_min : q == 0
module bcd_digit
   import bcd_pkg::*;
(
   input  logic       F_IN,
   input  logic       CLR,
   input  logic       ld,
   input  bcd_digit_t ld_val,
   input  logic       step,
   input  logic       up,
   output bcd_digit_t q,
   output logic       is_max,
   output logic       is_min
);

   bcd_digit_t q_q, q_d;

   always_ff @(posedge F_IN or posedge CLR) begin
      if (CLR) q_q <= BCD_MIN;
      else     q_q <= q_d;
   end

   always_comb begin
      q_d = q_q;
      if (ld) begin
         q_d = bcd_sat(ld_val);
      end else if (step) begin
         if (up) q_d = (q_q == BCD_MAX) ? BCD_MIN : q_q + 4'd1;
         else    q_d = (q_q == BCD_MIN) ? BCD_MAX : q_q - 4'd1;
      end
   end

   assign q      = q_q;
   assign is_max = (q_q == BCD_MAX);
   assign is_min = (q_q == BCD_MIN);

endmodule

// File: rtl/bcd_counter_n.sv
// bcd_counter_n: DIGITS-decade cascaded BCD counter clocked by F_IN.
//   F_IN  : count clock (rising edge)
//   CLR   : asynchronous active-high clear of Q, HOLD, CO, OVF
//   ENA   : count enable
//   UP    : 1 = count up, 0 = count down
//   LOAD  : synchronous load of D (digits >9 stored as 9); clears CO/OVF
//   D     : load value, digit k at D[4k+3:4k]
//   LATCH : HOLD <= pre-edge Q
//   Q     : live count
//   HOLD  : snapshot register
//   CO    : one-cycle registered wrap pulse (carry or borrow)
//   OVF   : sticky wrap flag
module bcd_counter_n
   import bcd_pkg::*;
#(
   parameter int unsigned DIGITS = 6
) (
   input  logic                F_IN,
   input  logic                CLR,
   input  logic                ENA,
   input  logic                UP,
   input  logic                LOAD,
   input  logic [4*DIGITS-1:0] D,
   input  logic                LATCH,
   output logic [4*DIGITS-1:0] Q,
   output logic [4*DIGITS-1:0] HOLD,
   output logic                CO,
   output logic                OVF
);

   logic [DIGITS-1:0] is_max, is_min, step_en;
   logic              wrap;

   logic [4*DIGITS-1:0] hold_q, hold_d;
   logic                co_q, co_d;
   logic                ovf_q, ovf_d;

   // Ripple of "all lower digits at the terminal value"; the final term is
   // the whole-counter terminal state, which is exactly the wrap condition.
   always_comb begin
      logic run;
      run     = 1'b1;
      step_en = '0;
      for (int unsigned k = 0; k < DIGITS; k++) begin
         step_en[k] = run;
         run        = run & (UP ? is_max[k] : is_min[k]);
      end
      wrap = ENA & ~LOAD & run;
   end

   for (genvar k = 0; k < DIGITS; k++) begin : g_digit
      bcd_digit u_digit (
         .F_IN   (F_IN),
         .CLR    (CLR),
         .ld     (LOAD),
         .ld_val (D[4*k +: 4]),
         .step   (ENA & ~LOAD & step_en[k]),
         .up     (UP),
         .q      (Q[4*k +: 4]),
         .is_max (is_max[k]),
         .is_min (is_min[k])
      );
   end

   always_ff @(posedge F_IN or posedge CLR) begin
      if (CLR) begin
         hold_q <= '0;
         co_q   <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         hold_q <= hold_d;
         co_q   <= co_d;
         ovf_q  <= ovf_d;
      end
   end

   always_comb begin
      hold_d = LATCH ? Q : hold_q;
      co_d   = wrap;
      ovf_d  = LOAD ? 1'b0 : (ovf_q | wrap);
   end

   assign HOLD = hold_q;
   assign CO   = co_q;
   assign OVF  = ovf_q;

endmodule

// File: tb/tb_bcd_counter_n.sv
// tb_bcd_counter_n: scoreboard bench for a 6-digit and a 2-digit counter
// sharing control inputs. Stimulus pushes expected post-edge values into a
// queue; a monitor pops one entry after each rising edge and compares.
module tb_bcd_counter_n;

   logic        clk = 1'b0;
   logic        clr, ena, up, load, latch;
   logic [23:0] d;
   logic [7:0]  d2;
   logic [23:0] q, hold;
   logic [7:0]  q2, hold2;
   logic        co, ovf, co2, ovf2;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [23:0] q;
      logic [23:0] hold;
      logic        co;
      logic        ovf;
      logic        chk2;
      logic [7:0]  q2;
      logic        co2;
      logic        ovf2;
      string       nm;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   bcd_counter_n #(.DIGITS(6)) u_dut6 (
      .F_IN(clk), .CLR(clr), .ENA(ena), .UP(up), .LOAD(load), .D(d),
      .LATCH(latch), .Q(q), .HOLD(hold), .CO(co), .OVF(ovf)
   );

   bcd_counter_n #(.DIGITS(2)) u_dut2 (
      .F_IN(clk), .CLR(clr), .ENA(ena), .UP(up), .LOAD(load), .D(d2),
      .LATCH(latch), .Q(q2), .HOLD(hold2), .CO(co2), .OVF(ovf2)
   );

   function automatic void chk(input string nm, input logic [31:0] act,
                               input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endfunction

   function automatic logic [23:0] bcd(input int unsigned v);
      return {4'd0, 4'd0, 4'd0, 4'd0, 4'(v / 10), 4'(v % 10)};
   endfunction

   // Drive one edge's inputs on the falling edge and queue the expectation.
   task automatic cyc(input logic e, u, l, lt,
                      input logic [23:0] dv, input logic [7:0] dv2,
                      input logic [23:0] eq, eh, input logic eco, eovf,
                      input logic c2, input logic [7:0] eq2,
                      input logic eco2, eovf2, input string nm);
      exp_t x;
      @(negedge clk);
      ena = e; up = u; load = l; latch = lt; d = dv; d2 = dv2;
      x.q = eq; x.hold = eh; x.co = eco; x.ovf = eovf;
      x.chk2 = c2; x.q2 = eq2; x.co2 = eco2; x.ovf2 = eovf2; x.nm = nm;
      sb.push_back(x);
   endtask

   initial begin : monitor
      exp_t x;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            x = sb.pop_front();
            chk({x.nm, ".q"},    32'(q),    32'(x.q));
            chk({x.nm, ".hold"}, 32'(hold), 32'(x.hold));
            chk({x.nm, ".co"},   32'(co),   32'(x.co));
            chk({x.nm, ".ovf"},  32'(ovf),  32'(x.ovf));
            if (x.chk2) begin
               chk({x.nm, ".q2"},    32'(q2),    32'(x.q2));
               chk({x.nm, ".hold2"}, 32'(hold2), 32'(x.hold[7:0]));
               chk({x.nm, ".co2"},   32'(co2),   32'(x.co2));
               chk({x.nm, ".ovf2"},  32'(ovf2),  32'(x.ovf2));
            end
         end
      end
   end

   task automatic chk_cleared(input string nm);
      chk({nm, ".q"},    32'(q),    0);
      chk({nm, ".hold"}, 32'(hold), 0);
      chk({nm, ".co"},   32'(co),   0);
      chk({nm, ".ovf"},  32'(ovf),  0);
      chk({nm, ".q2"},   32'(q2),   0);
   endtask

   initial begin : stim
      clr = 1'b1; ena = 1'b0; up = 1'b1; load = 1'b0; latch = 1'b0;
      d = '0; d2 = '0;
      #2;
      chk_cleared("reset");
      @(negedge clk);
      clr = 1'b0;

      // Count a few edges, snapshot on the 5th (captures pre-edge 4).
      for (int i = 1; i <= 5; i++)
         cyc(1, 1, 0, (i == 5), '0, '0, bcd(i), (i == 5) ? 24'h4 : 24'h0,
             0, 0, 1, bcd(i)[7:0], 0, 0, "count5");

      // Clear mid-count, away from any edge.
      @(negedge clk);
      ena = 1'b0; latch = 1'b0;
      #2;
      clr = 1'b1;
      #1;
      chk_cleared("clr_mid");
      @(negedge clk);
      clr = 1'b0;

      for (int i = 1; i <= 12; i++)
         cyc(1, 1, 0, 0, '0, '0, bcd(i), '0, 0, 0, 1, bcd(i)[7:0], 0, 0,
             "count12");

      // Up wrap.
      cyc(0, 1, 1, 0, 24'h999998, 8'h98, 24'h999998, '0, 0, 0, 1, 8'h98, 0, 0, "ld998");
      cyc(1, 1, 0, 0, '0, '0, 24'h999999, '0, 0, 0, 1, 8'h99, 0, 0, "up999");
      cyc(1, 1, 0, 0, '0, '0, 24'h000000, '0, 1, 1, 1, 8'h00, 1, 1, "upwrap");
      cyc(1, 1, 0, 0, '0, '0, 24'h000001, '0, 0, 1, 1, 8'h01, 0, 1, "postwrap");
      cyc(0, 1, 0, 0, '0, '0, 24'h000001, '0, 0, 1, 1, 8'h01, 0, 1, "ovfsticky");

      // Load clamp, LOAD beats ENA, OVF cleared.
      cyc(1, 1, 1, 0, 24'hA3F5C0, 8'hFA, 24'h939590, '0, 0, 0, 1, 8'h99, 0, 0, "ldclamp");

      // Down borrow and down wrap.
      cyc(0, 0, 1, 0, 24'h000010, 8'h10, 24'h000010, '0, 0, 0, 1, 8'h10, 0, 0, "ld10");
      cyc(1, 0, 0, 0, '0, '0, 24'h000009, '0, 0, 0, 1, 8'h09, 0, 0, "dn09");
      cyc(0, 0, 1, 0, '0, '0, 24'h000000, '0, 0, 0, 1, 8'h00, 0, 0, "ld00");
      cyc(1, 0, 0, 0, '0, '0, 24'h999999, '0, 1, 1, 1, 8'h99, 1, 1, "dnwrap");

      // LATCH with a concurrent count takes the pre-edge Q.
      cyc(0, 1, 1, 0, 24'h000041, 8'h41, 24'h000041, '0, 0, 0, 1, 8'h41, 0, 0, "ld41");
      cyc(1, 1, 0, 1, '0, '0, 24'h000042, 24'h41, 0, 0, 1, 8'h42, 0, 0, "latch");
      for (int i = 0; i < 5; i++)
         cyc(0, 1, 0, 0, '0, '0, 24'h000042, 24'h41, 0, 0, 1, 8'h42, 0, 0, "idle");

      // Direction change mid-count.
      cyc(0, 1, 1, 0, '0, '0, 24'h0, 24'h41, 0, 0, 1, 8'h00, 0, 0, "ld0");
      for (int i = 1; i <= 5; i++)
         cyc(1, 1, 0, 0, '0, '0, bcd(i), 24'h41, 0, 0, 1, bcd(i)[7:0], 0, 0, "dirup");
      for (int i = 4; i >= 0; i--)
         cyc(1, 0, 0, 0, '0, '0, bcd(i), 24'h41, 0, 0, 1, bcd(i)[7:0], 0, 0, "dirdn");
      cyc(1, 0, 0, 0, '0, '0, 24'h999999, 24'h41, 1, 1, 1, 8'h99, 1, 1, "dirwrap");
      cyc(1, 0, 0, 0, '0, '0, 24'h999998, 24'h41, 0, 1, 1, 8'h98, 0, 1, "dir998");

      @(negedge clk);
      ena = 1'b0;
      for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
      if (sb.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL drain: %0d entries left expected 0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
